// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive deframer and the transmit side.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int OVS_MID         = 7;
    localparam int DATA_BITS       = 8;
    localparam int CLK_DIV_DEFAULT = 27;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle oversample tick every CLK_DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = w_wrap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// 16x-oversampled UART receiver with a one-byte holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int OVS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [3:0] MID  = 4'(OVS_MID);
    localparam logic [3:0] LAST = 4'(OVS - 1);

    logic [1:0]           r_sync;
    logic                 r_rx_d;
    logic                 w_rx;
    logic                 w_fall;
    logic                 w_tick;
    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [3:0]           r_cnt;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_start;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;
    logic                 w_take_bit;
    logic                 w_take_stop;
    logic                 w_par_bad;
    logic                 w_good;
`ifdef UART_RX_PARITY_EN
    logic                 w_take_par;
    logic                 r_par_err;
    logic                 r_parity_err;
`endif

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    assign w_rx    = r_sync[1];
    assign w_fall  = r_rx_d & ~w_rx;
    assign rx_busy = (r_state != ST_IDLE);
    assign w_good  = w_take_stop & w_rx & ~w_par_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx_in};
            r_rx_d <= w_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_take_bit  = 1'b0;
        w_take_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_take_par  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_start     = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_cnt != MID) begin
                        w_cnt_inc = 1'b1;
                    end else if (w_rx) begin
                        w_state_nxt = ST_IDLE;  // line went back high: glitch, not a start bit
                    end else begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_cnt != LAST) begin
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_cnt_clr  = 1'b1;
                        w_take_bit = 1'b1;
                        if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    if (r_cnt != LAST) begin
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_cnt_clr   = 1'b1;
                        w_take_par  = 1'b1;
                        w_state_nxt = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (w_tick) begin
                    if (r_cnt != LAST) begin
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_take_stop = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_bit     <= 3'd0;
            r_shift   <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_take_stop & ~w_rx;
            overrun   <= w_good & rx_valid & ~rd_en;
            if (w_cnt_clr) begin
                r_cnt <= 4'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_start) begin
                r_bit <= 3'd0;
            end else if (w_take_bit) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_take_bit) begin
                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            end
            // A pop in the same cycle frees the holding register for the new byte.
            if (w_good && (!rx_valid || rd_en)) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rd_en) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_take_stop & w_rx & r_par_err;
            if (w_start) begin
                r_par_err <= 1'b0;
            end else if (w_take_par) begin
                r_par_err <= w_rx ^ (^r_shift);
            end
        end
    end

    assign w_par_bad  = r_par_err;
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames plus randomized frames against a byte-level model.
module tb_uart_rx_deframer;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_BITS = PAR ? 11 : 10;
    localparam int LAT_NOM    = (FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cnt_fe  = 0;
    int cnt_ov  = 0;
    int cnt_pe  = 0;
    int s_fe, s_ov, s_pe;

    logic       m_valid;
    logic [7:0] m_data;

    uart_rx_deframer #(.CLK_DIV(CLK_DIV), .OVS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rd_en      (rd_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cnt_fe <= cnt_fe + (frame_err  === 1'b1 ? 1 : 0);
        cnt_ov <= cnt_ov + (overrun    === 1'b1 ? 1 : 0);
        cnt_pe <= cnt_pe + (parity_err === 1'b1 ? 1 : 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_fe = cnt_fe;
        s_ov = cnt_ov;
        s_pe = cnt_pe;
    endtask

    task automatic check_flags(input string tag, input int fe, input int ov, input int pe);
        check({tag, "_frame_err"},  cnt_fe - s_fe, fe);
        check({tag, "_overrun"},    cnt_ov - s_ov, ov);
        check({tag, "_parity_err"}, cnt_pe - s_pe, pe);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick_n(1);
        rd_en = 1'b0;
    endtask

    // Full frame, ends at the end of the stop bit with the line back high.
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        rx_in = 1'b0;
        tick_n(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            tick_n(BIT_CLKS);
        end
        if (PAR) begin
            rx_in = par_bit;
            tick_n(BIT_CLKS);
        end
        rx_in = stop_bit;
        tick_n(BIT_CLKS);
        rx_in = 1'b1;
    endtask

    task automatic wait_valid_rise(input int budget, output int at, output logic busy_before, output logic busy_at);
        logic pb;
        at          = -1;
        busy_before = 1'bx;
        busy_at     = 1'bx;
        pb          = rx_busy;
        for (int i = 0; i < budget; i++) begin
            tick_n(1);
            if (rx_valid === 1'b1) begin
                at          = cyc;
                busy_before = pb;
                busy_at     = rx_busy;
                return;
            end
            pb = rx_busy;
        end
    endtask

    // Byte-level reference: outcome of one frame given the consumer made no pop during it.
    task automatic model_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                               output int fe, output int ov, output int pe);
        fe = 0;
        ov = 0;
        pe = 0;
        if (!stop_bit) begin
            fe = 1;
        end else if (PAR && (par_bit != ^d)) begin
            pe = 1;
        end else if (m_valid) begin
            ov = 1;
        end else begin
            m_valid = 1'b1;
            m_data  = d;
        end
    endtask

    initial begin
        int         t0, at, lat, target, efe, eov, epe, gap;
        logic       bb, ba, stop_b, par_b;
        logic [7:0] d;

        rst = 1'b1;
        tick_n(5);
        check("rst_rx_valid",  rx_valid,   1'b0);
        check("rst_rx_data",   rx_data,    8'h00);
        check("rst_rx_busy",   rx_busy,    1'b0);
        check("rst_frame_err", frame_err,  1'b0);
        check("rst_overrun",   overrun,    1'b0);
        check("rst_parity",    parity_err, 1'b0);
        rst = 1'b0;
        tick_n(10);

        // Single good byte and its latency relative to the stop mid-sample
        snap();
        t0 = cyc;
        fork
            send_frame(8'hA5, ^8'hA5, 1'b1);
            wait_valid_rise(3000, at, bb, ba);
        join
        lat = at - t0;
        check("a5_seen",       (at >= 0), 1);
        check("a5_lat_window", (lat >= LAT_NOM - 2) && (lat <= LAT_NOM + 6), 1);
        check("a5_busy_before", bb, 1'b1);
        check("a5_busy_at",     ba, 1'b0);
        check("a5_data",        rx_data, 8'hA5);
        check_flags("a5", 0, 0, 0);
        pop();
        check("a5_pop_clears", rx_valid, 1'b0);
        pop();
        check("pop_empty_ignored", rx_valid, 1'b0);
        check("pop_empty_data",    rx_data, 8'hA5);

        // Short low pulse must not be taken for a start bit
        snap();
        rx_in = 1'b0;
        tick_n(10);
        check("glitch_busy_seen", rx_busy, 1'b1);
        tick_n(10);
        rx_in = 1'b1;
        tick_n(60);
        check("glitch_busy_idle", rx_busy, 1'b0);
        check("glitch_valid",     rx_valid, 1'b0);
        check_flags("glitch", 0, 0, 0);

        // Stop bit held low
        snap();
        send_frame(8'h3C, ^8'h3C, 1'b0);
        tick_n(10);
        check("ferr_valid", rx_valid, 1'b0);
        check_flags("ferr", 1, 0, 0);

        // Back-to-back with no pop: second byte dropped
        snap();
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        tick_n(4);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_data",  rx_data, 8'h11);
        check_flags("ovr", 0, 1, 0);
        pop();
        check("ovr_pop", rx_valid, 1'b0);

        // Back-to-back with a pop on exactly the second load cycle
        snap();
        t0 = cyc;
        fork
            begin
                send_frame(8'h11, ^8'h11, 1'b1);
                send_frame(8'h22, ^8'h22, 1'b1);
            end
            begin
                wait_valid_rise(3000, at, bb, ba);
                check("b2b_first_seen", (at >= 0), 1);
                target = t0 + FRAME_BITS * BIT_CLKS + (at - t0);
                for (int g = 0; g < 3000 && cyc < target - 1; g++) tick_n(1);
                check("b2b_align",    cyc, target - 1);
                check("b2b_pre_valid", rx_valid, 1'b1);
                check("b2b_pre_data",  rx_data, 8'h11);
                rd_en = 1'b1;
                tick_n(1);
                rd_en = 1'b0;
                check("b2b_load_valid", rx_valid, 1'b1);
                check("b2b_load_data",  rx_data, 8'h22);
            end
        join
        tick_n(4);
        check_flags("b2b", 0, 0, 0);
        pop();

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        tick_n(4);
        check("par_bad_valid", rx_valid, 1'b0);
        check_flags("par_bad", 0, 0, 1);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        tick_n(4);
        check("par_ok_valid", rx_valid, 1'b1);
        check("par_ok_data",  rx_data, 8'h07);
        check_flags("par_ok", 0, 0, 0);
        pop();
`endif

        // Reset in the middle of data bit 4 of 0xFF, with a byte still held
        send_frame(8'h99, ^8'h99, 1'b1);
        tick_n(4);
        check("pre_rst_data", rx_data, 8'h99);
        rx_in = 1'b0;
        tick_n(BIT_CLKS);
        rx_in = 1'b1;
        tick_n(4 * BIT_CLKS + BIT_CLKS / 2);
        check("midframe_busy", rx_busy, 1'b1);
        rst = 1'b1;
        tick_n(2);
        check("midrst_busy",  rx_busy,  1'b0);
        check("midrst_valid", rx_valid, 1'b0);
        check("midrst_data",  rx_data,  8'h00);
        rst = 1'b0;
        snap();
        tick_n(6 * BIT_CLKS);
        check("postrst_busy",  rx_busy,  1'b0);
        check("postrst_valid", rx_valid, 1'b0);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        tick_n(4);
        check("postrst_5a_valid", rx_valid, 1'b1);
        check("postrst_5a_data",  rx_data,  8'h5A);
        check_flags("postrst", 0, 0, 0);

        // Randomized frames against the byte-level model
        m_valid = 1'b1;
        m_data  = 8'h5A;
        stop_b  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 40);
            if (!stop_b && gap < 8) gap = 8;
            tick_n(gap);
            if ($urandom_range(0, 2) == 0) begin
                pop();
                m_valid = 1'b0;
            end
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            par_b  = (^d) ^ ($urandom_range(0, 5) == 0);
            snap();
            send_frame(d, par_b, stop_b);
            model_frame(d, par_b, stop_b, efe, eov, epe);
            check($sformatf("rnd%0d_valid", k), rx_valid, m_valid);
            check($sformatf("rnd%0d_data", k),  rx_data,  m_data);
            check_flags($sformatf("rnd%0d", k), efe, eov, epe);
        end

        tick_n(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, system clocks per 16x oversample tick (50 MHz / 115200 baud / 16).
REQ-002 SHALL have parameter OVS, default 16, oversample ticks per bit.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_in, input, 1, asynchronous serial line, idle high, driven by upstream tx_out.
REQ-006 SHALL have port rd_en, input, 1, consumer pop of the holding register.
REQ-007 SHALL have port rx_data, output, 8, received byte.
REQ-008 SHALL have port rx_valid, output, 1, holding register full.
REQ-009 SHALL have port rx_busy, output, 1, FSM not in IDLE.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a byte is dropped.
REQ-012 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch; tied 0 when the parity feature is excluded.

Function
REQ-013 SHALL pass rx_in through a 2-FF synchroniser reset to 1; all FSM decisions use the synchronised value.
REQ-014 SHALL generate a one-cycle tick every CLK_DIV clocks; the divider is free-running.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: on a synchronised falling edge, clear the tick count and go to START.
REQ-017 START: at tick count 7 (mid-bit), if the line is high return to IDLE with no flags (glitch); otherwise restart the count and go to DATA.
REQ-018 DATA: sample every 16 ticks at mid-bit, LSB first, 8 bits; after bit 7 go to PARITY if enabled, else STOP.
REQ-019 PARITY: sample one bit; mismatch against even parity of the 8 data bits sets an internal error flag; go to STOP.
REQ-020 STOP: sample mid-bit, then return to IDLE immediately, without waiting for the bit end, so back-to-back frames are accepted.
REQ-021 Stop sampled 0: pulse frame_err, discard the byte, leave rx_valid unchanged.
REQ-022 Parity error with stop 1: pulse parity_err, discard the byte.
REQ-023 Good byte: rx_data and rx_valid update on the clock after the stop sample (1-cycle latency).
REQ-024 rd_en while rx_valid=1 clears rx_valid next cycle; rd_en while rx_valid=0 is ignored.
REQ-025 Good byte while rx_valid=1 and rd_en=0: pulse overrun, keep the old rx_data, drop the new byte.
REQ-026 Good byte in the same cycle as rd_en with rx_valid=1: load the new byte, rx_valid stays 1, no overrun.
REQ-027 Sample and bit counters SHALL be 4 and 3 bits, wrapping naturally; no other arithmetic.

Reset
REQ-028 While rst=1: FSM=IDLE; counters=0; synchroniser=1; rx_data=8'h00; rx_valid, rx_busy, frame_err, overrun, parity_err=0.
REQ-029 Reset mid-frame SHALL abandon the frame; no flag pulses after release; the next falling edge starts a fresh frame.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: the frame is start, 8 data, even parity, stop; the PARITY state and parity_err are active.
REQ-031 Macro UART_RX_PARITY_EN undefined: the frame is start, 8 data, stop; the PARITY state is unreachable/removed; parity_err is constant 0.

Structure
REQ-032 Shared package uart_pkg SHALL hold the state encodings (IDLE..STOP), OVS_MID=7, DATA_BITS=8 and the default CLK_DIV, shared with the transmit side.
REQ-033 Sub-module uart_baud_tick SHALL implement the CLK_DIV tick divider and be reusable by the transmitter; everything else stays in uart_rx_deframer.

Verification (CLK_DIV=4, one bit = 64 clocks)
REQ-034 Send 8'hA5 with a good stop bit -> rx_valid=1 and rx_data=8'hA5 exactly 1 cycle after the stop mid-sample; rd_en then clears rx_valid.
REQ-035 Pull rx_in low for 20 clocks, then high -> FSM returns to IDLE, rx_valid=0, no flag pulses.
REQ-036 Send 8'h3C with the stop bit held low -> frame_err pulses once, rx_valid stays 0.
REQ-037 Send 8'h11 then 8'h22 back-to-back with no rd_en -> rx_data=8'h11, overrun pulses once; repeat with rd_en on the load cycle -> rx_data=8'h22, no overrun.
REQ-038 With UART_RX_PARITY_EN, send 8'h07 with parity 0 (wrong) -> parity_err pulses, byte discarded; parity 1 -> byte delivered.
REQ-039 Assert rst at DATA bit 4 of 8'hFF, release, then send 8'h5A -> all outputs reset, only 8'h5A received, no error pulses.
